// File: rtl/pet_stats_pkg.sv
// rtl/pet_stats_pkg.sv - shared widths, stat indices and arbiter state encoding for the pet stat block
package pet_stats_pkg;

    localparam int STAT_W    = 4;
    localparam int NUM_STATS = 6;

    localparam logic [2:0] IDX_HUNGER    = 3'd0;
    localparam logic [2:0] IDX_HAPPINESS = 3'd1;
    localparam logic [2:0] IDX_HEALTH    = 3'd2;
    localparam logic [2:0] IDX_HYGIENE   = 3'd3;
    localparam logic [2:0] IDX_ENERGY    = 3'd4;
    localparam logic [2:0] IDX_SOCIAL    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    function automatic logic idx_valid(input logic [2:0] idx);
        return idx < 3'(NUM_STATS);
    endfunction

endpackage

// File: rtl/stat_update_arbiter_if.sv
// rtl/stat_update_arbiter_if.sv - request/grant and update-report bundle between requesters and the stat arbiter
interface stat_update_arbiter_if;

    logic       dec_req;
    logic [2:0] dec_idx;
    logic [2:0] dec_delta;
    logic       dec_gnt;

    logic       usr_req;
    logic [2:0] usr_idx;
    logic [2:0] usr_delta;
    logic       usr_gnt;

    logic       upd_valid;
    logic [2:0] upd_idx;
    logic       upd_err;

    modport master (
        output dec_req, dec_idx, dec_delta,
        output usr_req, usr_idx, usr_delta,
        input  dec_gnt, usr_gnt,
        input  upd_valid, upd_idx, upd_err
    );

    modport slave (
        input  dec_req, dec_idx, dec_delta,
        input  usr_req, usr_idx, usr_delta,
        output dec_gnt, usr_gnt,
        output upd_valid, upd_idx, upd_err
    );

endinterface

// File: rtl/stat_sat_adder.sv
// rtl/stat_sat_adder.sv - combinational stat plus signed 3-bit delta, clamped to [0, STAT_MAX]
module stat_sat_adder #(
    parameter int STAT_W   = 4,
    parameter int STAT_MAX = 15
) (
    input  logic [STAT_W-1:0] stat,
    input  logic [2:0]        delta,
    output logic [STAT_W-1:0] result
);

    localparam logic signed [STAT_W+1:0] MAX_S = (STAT_W+2)'(STAT_MAX);
    localparam logic [STAT_W-1:0]        MAX_R = STAT_W'(STAT_MAX);

    logic signed [STAT_W+1:0] sum;

    // Two guard bits keep both underflow below zero and overflow past 2**STAT_W-1 representable.
    always_comb begin
        sum = $signed({2'b00, stat}) + $signed({{(STAT_W-1){delta[2]}}, delta});
        if (sum[STAT_W+1]) begin
            result = '0;
        end else if (sum > MAX_S) begin
            result = MAX_R;
        end else begin
            result = sum[STAT_W-1:0];
        end
    end

endmodule

// File: rtl/stat_update_arbiter.sv
// rtl/stat_update_arbiter.sv - round-robin decay/user arbiter and sole writer of the six pet stats; CARE_COOLDOWN_EN adds a user lockout
module stat_update_arbiter
    import pet_stats_pkg::*;
#(
    parameter int STAT_W          = pet_stats_pkg::STAT_W,
    parameter int STAT_MAX        = 15,
    parameter int STAT_INIT       = 0,
    parameter int COOLDOWN_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    stat_update_arbiter_if.slave bus,
    output logic [STAT_W-1:0]    hunger,
    output logic [STAT_W-1:0]    happiness,
    output logic [STAT_W-1:0]    health,
    output logic [STAT_W-1:0]    hygiene,
    output logic [STAT_W-1:0]    energy,
    output logic [STAT_W-1:0]    social,
    output logic                 busy,
    output logic                 cooldown_active
);

    arb_state_e        state;
    logic              prefer_usr;
    logic              lat_usr;
    logic [2:0]        lat_idx;
    logic [2:0]        lat_delta;
    logic [STAT_W-1:0] stats [NUM_STATS];
    logic [STAT_W-1:0] cur_stat;
    logic [STAT_W-1:0] new_stat;
    logic              usr_eligible;
    logic              usr_wins;

    assign usr_eligible = bus.usr_req & ~cooldown_active;
    assign usr_wins     = usr_eligible & (~bus.dec_req | prefer_usr);

    always_comb begin
        cur_stat = '0;
        for (int i = 0; i < NUM_STATS; i++) begin
            if (lat_idx == 3'(i)) cur_stat = stats[i];
        end
    end

    stat_sat_adder #(
        .STAT_W   (STAT_W),
        .STAT_MAX (STAT_MAX)
    ) u_adder (
        .stat   (cur_stat),
        .delta  (lat_delta),
        .result (new_stat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            prefer_usr    <= 1'b1;
            lat_usr       <= 1'b0;
            lat_idx       <= '0;
            lat_delta     <= '0;
            bus.dec_gnt   <= 1'b0;
            bus.usr_gnt   <= 1'b0;
            bus.upd_valid <= 1'b0;
            bus.upd_idx   <= '0;
            bus.upd_err   <= 1'b0;
            for (int i = 0; i < NUM_STATS; i++) stats[i] <= STAT_W'(STAT_INIT);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (usr_eligible || bus.dec_req) begin
                        state       <= ST_APPLY;
                        lat_usr     <= usr_wins;
                        lat_idx     <= usr_wins ? bus.usr_idx : bus.dec_idx;
                        lat_delta   <= usr_wins ? bus.usr_delta : bus.dec_delta;
                        bus.usr_gnt <= usr_wins;
                        bus.dec_gnt <= ~usr_wins;
                        prefer_usr  <= ~usr_wins;
                    end
                end
                ST_APPLY: begin
                    bus.usr_gnt   <= 1'b0;
                    bus.dec_gnt   <= 1'b0;
                    // Out-of-range indices match no entry, so they leave every stat untouched.
                    for (int i = 0; i < NUM_STATS; i++) begin
                        if (lat_idx == 3'(i)) stats[i] <= new_stat;
                    end
                    bus.upd_valid <= 1'b1;
                    bus.upd_idx   <= lat_idx;
                    bus.upd_err   <= ~idx_valid(lat_idx);
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    bus.upd_valid <= 1'b0;
                    bus.upd_err   <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CARE_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);

    logic [CD_W-1:0] cd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cd_cnt <= '0;
        end else if (state == ST_APPLY && lat_usr) begin
            cd_cnt <= CD_W'(COOLDOWN_CYCLES);
        end else if (cd_cnt != '0) begin
            cd_cnt <= cd_cnt - CD_W'(1);
        end
    end

    assign cooldown_active = (cd_cnt != '0);
`else
    assign cooldown_active = 1'b0 & (COOLDOWN_CYCLES < 0);
`endif

    assign busy      = (state != ST_IDLE);
    assign hunger    = stats[IDX_HUNGER];
    assign happiness = stats[IDX_HAPPINESS];
    assign health    = stats[IDX_HEALTH];
    assign hygiene   = stats[IDX_HYGIENE];
    assign energy    = stats[IDX_ENERGY];
    assign social    = stats[IDX_SOCIAL];

endmodule
